// File: rtl/operand_encoder_pkg.sv
// Shared types and constants for the x86-64 operand encoder: rm kinds, FSM states,
// REX bit positions, fixed prefix/SIB bytes and the ModRM packing helper.
package operand_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_REG      = 3'd0,
    KIND_BASE     = 3'd1,
    KIND_BASE_D8  = 3'd2,
    KIND_BASE_D32 = 3'd3,
    KIND_RIP_D32  = 3'd4
  } rm_kind_t;

  typedef enum logic [2:0] {
    S_IDLE, S_PFX, S_REX, S_OPC, S_MODRM, S_SIB, S_DISP, S_IMM
  } state_t;

  localparam int REX_W = 3;
  localparam int REX_R = 2;
  localparam int REX_X = 1;
  localparam int REX_B = 0;

  localparam logic [7:0] PFX_OPSIZE = 8'h66;
  localparam logic [7:0] REX_BASE   = 8'h40;
  localparam logic [7:0] SIB_RSP    = 8'h24;
  localparam logic [2:0] RM_RIP     = 3'b101;
  localparam logic [2:0] RM_SIB     = 3'b100;

  function automatic logic [7:0] modrm_byte(input logic [1:0] mod_f,
                                            input logic [2:0] reg_f,
                                            input logic [2:0] rm_f);
    return {mod_f, reg_f, rm_f};
  endfunction

endpackage

// File: rtl/operand_encoder_if.sv
// Request and byte-stream bundle of the operand encoder; master drives requests
// and consumes bytes, slave is the encoder.
interface operand_encoder_if #(
  parameter int OUT_CNT_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_opsize16;
  logic                 in_rex_w;
  logic [7:0]           in_opcode;
  logic                 in_has_modrm;
  logic [3:0]           in_reg;
  logic [2:0]           in_rm_kind;
  logic [3:0]           in_rm_reg;
  logic [31:0]          in_disp;
  logic [63:0]          in_imm;
  logic [3:0]           in_imm_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_byte;
  logic                 out_last;
  logic [OUT_CNT_W-1:0] out_count;
  logic                 err;

  modport master (
    output in_valid, in_opsize16, in_rex_w, in_opcode, in_has_modrm, in_reg,
           in_rm_kind, in_rm_reg, in_disp, in_imm, in_imm_len, out_ready,
    input  in_ready, out_valid, out_byte, out_last, out_count, err
  );

  modport slave (
    input  in_valid, in_opsize16, in_rex_w, in_opcode, in_has_modrm, in_reg,
           in_rm_kind, in_rm_reg, in_disp, in_imm, in_imm_len, out_ready,
    output in_ready, out_valid, out_byte, out_last, out_count, err
  );
endinterface

// File: rtl/operand_encoder_le_field_shifter.sv
// Little-endian field serializer: loads up to MAX_BYTES bytes plus a length and
// presents them LSB first, one byte per advance strobe.
module le_field_shifter #(
  parameter  int MAX_BYTES = 8,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [8*MAX_BYTES-1:0] load_data,
  input  logic [LEN_W-1:0]       load_len,
  input  logic                   advance,
  output logic [7:0]             byte_o,
  output logic                   last_o,
  output logic                   done_o
);
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       len_q, len_d;

  assign byte_o = data_q[7:0];
  assign done_o = (idx_q == len_q);
  assign last_o = ((idx_q + LEN_W'(1)) == len_q);

  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    len_d  = len_q;
    if (load) begin
      data_d = load_data;
      idx_d  = '0;
      len_d  = load_len;
    end else if (advance && !done_o) begin
      data_d = data_q >> 8;
      idx_d  = idx_q + LEN_W'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      idx_q  <= '0;
      len_q  <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
    end
  end
endmodule

// File: rtl/operand_encoder.sv
// Serializes one resolved x86-64 instruction into its machine-code bytes:
// [66] [REX] opcode [ModRM] [SIB] [disp] [imm], one byte per stream handshake.
module operand_encoder
  import operand_encoder_pkg::*;
#(
  parameter int OUT_CNT_W = 5
) (
  input logic              clk,
  input logic              reset,
  operand_encoder_if.slave bus
);
  state_t               state_q, state_d;
  logic                 pfx_en_q, pfx_en_d;
  logic [7:0]           rex_q, rex_d;
  logic [7:0]           opcode_q, opcode_d;
  logic                 modrm_en_q, modrm_en_d;
  logic [7:0]           modrm_q, modrm_d;
  logic                 sib_en_q, sib_en_d;
  logic [OUT_CNT_W-1:0] count_q, count_d;
  logic                 err_q, err_d;

  logic [1:0]  mod_f;
  logic [2:0]  rm_f;
  logic [3:0]  disp_len;
  logic [31:0] disp_v;
  logic        is_mem, sib_en, req_ok;
  logic [7:0]  rex_v;
  logic        capture, load, hs, out_valid;
  logic [7:0]  byte_mux;
  logic        field_done;
  state_t      nxt, after_disp, after_sib;
  logic        disp_adv, imm_adv;
  logic [7:0]  disp_byte, imm_byte;
  logic        disp_last, disp_done, imm_last, imm_done;

  // Request decode: field values and lengths, evaluated while a request is offered.
  always_comb begin
    mod_f    = 2'b00;
    rm_f     = bus.in_rm_reg[2:0];
    disp_len = 4'd0;
    disp_v   = bus.in_disp;
    is_mem   = 1'b0;
    case (bus.in_rm_kind)
      KIND_REG: mod_f = 2'b11;
      KIND_BASE: begin
        is_mem = 1'b1;
        // rbp/r13 with mod=00 would mean RIP/disp32, so use a zero disp8 instead.
        if (bus.in_rm_reg[2:0] == RM_RIP) begin
          mod_f    = 2'b01;
          disp_len = 4'd1;
          disp_v   = '0;
        end
      end
      KIND_BASE_D8: begin
        is_mem   = 1'b1;
        mod_f    = 2'b01;
        disp_len = 4'd1;
      end
      KIND_BASE_D32: begin
        is_mem   = 1'b1;
        mod_f    = 2'b10;
        disp_len = 4'd4;
      end
      KIND_RIP_D32: begin
        rm_f     = RM_RIP;
        disp_len = 4'd4;
      end
      default: ;
    endcase
    if (!bus.in_has_modrm) begin
      is_mem   = 1'b0;
      disp_len = 4'd0;
    end
    sib_en = is_mem && (bus.in_rm_reg[2:0] == RM_SIB);

    rex_v        = REX_BASE;
    rex_v[REX_W] = bus.in_rex_w;
    rex_v[REX_R] = bus.in_reg[3] & bus.in_has_modrm;
    rex_v[REX_X] = 1'b0;
    rex_v[REX_B] = bus.in_rm_reg[3];

    req_ok = (bus.in_imm_len inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8}) &&
             (!bus.in_has_modrm || (bus.in_rm_kind < 3'd5));
  end

  assign out_valid = (state_q != S_IDLE);
  assign hs        = out_valid && bus.out_ready;
  assign capture   = bus.in_valid && (state_q == S_IDLE);
  assign load      = capture && req_ok;

  le_field_shifter #(.MAX_BYTES(8)) u_disp (
    .clk(clk), .reset(reset), .load(load), .load_data({32'h0, disp_v}),
    .load_len(disp_len), .advance(disp_adv),
    .byte_o(disp_byte), .last_o(disp_last), .done_o(disp_done)
  );

  le_field_shifter #(.MAX_BYTES(8)) u_imm (
    .clk(clk), .reset(reset), .load(load), .load_data(bus.in_imm),
    .load_len(bus.in_imm_len), .advance(imm_adv),
    .byte_o(imm_byte), .last_o(imm_last), .done_o(imm_done)
  );

  // Empty fields are skipped; the shifters report empty before their state is entered.
  assign after_disp = imm_done  ? S_IDLE : S_IMM;
  assign after_sib  = disp_done ? after_disp : S_DISP;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    pfx_en_d   = pfx_en_q;
    rex_d      = rex_q;
    opcode_d   = opcode_q;
    modrm_en_d = modrm_en_q;
    modrm_d    = modrm_q;
    sib_en_d   = sib_en_q;
    count_d    = count_q;
    err_d      = 1'b0;
    byte_mux   = 8'h00;
    field_done = 1'b1;
    nxt        = S_IDLE;
    disp_adv   = 1'b0;
    imm_adv    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          err_d = !req_ok;
          if (req_ok) begin
            pfx_en_d   = bus.in_opsize16;
            rex_d      = rex_v;
            opcode_d   = bus.in_opcode;
            modrm_en_d = bus.in_has_modrm;
            modrm_d    = modrm_byte(mod_f, bus.in_reg[2:0], rm_f);
            sib_en_d   = sib_en;
            count_d    = OUT_CNT_W'(bus.in_opsize16) + OUT_CNT_W'(rex_v != REX_BASE) +
                         OUT_CNT_W'(1) + OUT_CNT_W'(bus.in_has_modrm) + OUT_CNT_W'(sib_en) +
                         OUT_CNT_W'(disp_len) + OUT_CNT_W'(bus.in_imm_len);
            if (bus.in_opsize16)        state_d = S_PFX;
            else if (rex_v != REX_BASE) state_d = S_REX;
            else                        state_d = S_OPC;
          end
        end
      end
      S_PFX: begin
        byte_mux = PFX_OPSIZE;
        nxt      = (rex_q != REX_BASE) ? S_REX : S_OPC;
      end
      S_REX: begin
        byte_mux = rex_q;
        nxt      = S_OPC;
      end
      S_OPC: begin
        byte_mux = opcode_q;
        nxt      = modrm_en_q ? S_MODRM : after_sib;
      end
      S_MODRM: begin
        byte_mux = modrm_q;
        nxt      = sib_en_q ? S_SIB : after_sib;
      end
      S_SIB: begin
        byte_mux = SIB_RSP;
        nxt      = after_sib;
      end
      S_DISP: begin
        byte_mux   = disp_byte;
        field_done = disp_last;
        nxt        = after_disp;
        disp_adv   = hs;
      end
      S_IMM: begin
        byte_mux   = imm_byte;
        field_done = imm_last;
        nxt        = S_IDLE;
        imm_adv    = hs;
      end
      default: ;
    endcase
    if (out_valid && hs && field_done) state_d = nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pfx_en_q   <= 1'b0;
      rex_q      <= REX_BASE;
      opcode_q   <= 8'h00;
      modrm_en_q <= 1'b0;
      modrm_q    <= 8'h00;
      sib_en_q   <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pfx_en_q   <= pfx_en_d;
      rex_q      <= rex_d;
      opcode_q   <= opcode_d;
      modrm_en_q <= modrm_en_d;
      modrm_q    <= modrm_d;
      sib_en_q   <= sib_en_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_byte  = byte_mux;
  assign bus.out_last  = out_valid && field_done && (nxt == S_IDLE);
  assign bus.out_count = out_valid ? count_q : '0;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_operand_encoder.sv
// Self-checking bench for operand_encoder: directed vector table, corner sequences
// (backpressure, error, reset mid-instruction) and randomized requests vs a byte-list model.
module tb_operand_encoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_encoder_if #(.OUT_CNT_W(5)) bus ();
  operand_encoder #(.OUT_CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic        opsize16;
    logic        rex_w;
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [3:0]  reg_f;
    logic [2:0]  rm_kind;
    logic [3:0]  rm_reg;
    logic [31:0] disp;
    logic [63:0] imm;
    logic [3:0]  imm_len;
  } req_t;

  typedef struct {
    req_t         r;
    int           n;
    logic [135:0] bytes;  // first emitted byte in the most significant of n bytes
    bit           err;
    int           stall;
  } vec_t;

  localparam int NV = 11;
  vec_t       tbl[NV];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  bit         exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic opsize16, input logic rex_w, input logic [7:0] opcode,
                              input logic has_modrm, input logic [3:0] reg_f,
                              input logic [2:0] rm_kind, input logic [3:0] rm_reg,
                              input logic [31:0] disp, input logic [63:0] imm,
                              input logic [3:0] imm_len);
    req_t r;
    r.opsize16 = opsize16; r.rex_w = rex_w; r.opcode = opcode; r.has_modrm = has_modrm;
    r.reg_f = reg_f; r.rm_kind = rm_kind; r.rm_reg = rm_reg; r.disp = disp;
    r.imm = imm; r.imm_len = imm_len;
    return r;
  endfunction

  // Reference: builds the expected byte list straight from the encoding rules.
  task automatic model(input req_t r);
    int          kind, mod_v, rm_v, dl;
    logic [31:0] d;
    logic [7:0]  rex;
    exp_q.delete();
    kind    = int'(r.rm_kind);
    d       = r.disp;
    exp_err = !(r.imm_len inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8}) ||
              (r.has_modrm && r.rm_kind >= 3'd5);
    if (exp_err) return;
    if (r.has_modrm && kind == 1 && r.rm_reg[2:0] == 3'd5) begin
      kind = 2;
      d    = '0;
    end
    if (r.opsize16) exp_q.push_back(8'h66);
    rex = 8'h40 + (r.rex_w ? 8'h08 : 8'h00) + ((r.reg_f[3] && r.has_modrm) ? 8'h04 : 8'h00) +
          (r.rm_reg[3] ? 8'h01 : 8'h00);
    if (rex != 8'h40) exp_q.push_back(rex);
    exp_q.push_back(r.opcode);
    if (r.has_modrm) begin
      mod_v = (kind == 0) ? 3 : (kind == 2) ? 1 : (kind == 3) ? 2 : 0;
      rm_v  = (kind == 4) ? 5 : int'(r.rm_reg[2:0]);
      exp_q.push_back(8'(mod_v * 64 + int'(r.reg_f[2:0]) * 8 + rm_v));
      if (kind >= 1 && kind <= 3 && r.rm_reg[2:0] == 3'd4) exp_q.push_back(8'h24);
      dl = (kind == 2) ? 1 : (kind == 3 || kind == 4) ? 4 : 0;
      for (int i = 0; i < dl; i++) exp_q.push_back(8'(d >> (8 * i)));
    end
    for (int i = 0; i < int'(r.imm_len); i++) exp_q.push_back(8'(r.imm >> (8 * i)));
  endtask

  task automatic load_vec(input int i);
    exp_q.delete();
    exp_err = tbl[i].err;
    for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(tbl[i].bytes[8 * (tbl[i].n - 1 - k) +: 8]);
  endtask

  task automatic apply(input req_t r);
    bus.in_opsize16  = r.opsize16;
    bus.in_rex_w     = r.rex_w;
    bus.in_opcode    = r.opcode;
    bus.in_has_modrm = r.has_modrm;
    bus.in_reg       = r.reg_f;
    bus.in_rm_kind   = r.rm_kind;
    bus.in_rm_reg    = r.rm_reg;
    bus.in_disp      = r.disp;
    bus.in_imm       = r.imm;
    bus.in_imm_len   = r.imm_len;
  endtask

  // Issues one request at a negedge and checks the whole response against exp_q/exp_err.
  task automatic send(input req_t r, input int stall_n, input bit rand_ready);
    int cyc, got, stall;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_before_req", 64'(bus.in_ready), 64'd1);
    apply(r);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (exp_err) begin
      check("err_pulse", 64'(bus.err), 64'd1);
      check("err_no_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check("err_one_cycle", 64'(bus.err), 64'd0);
      check("err_in_ready", 64'(bus.in_ready), 64'd1);
      check("err_no_valid2", 64'(bus.out_valid), 64'd0);
      return;
    end
    check("first_byte_latency", 64'(bus.out_valid), 64'd1);
    check("no_err", 64'(bus.err), 64'd0);
    got   = 0;
    cyc   = 0;
    stall = stall_n;
    while (got < exp_q.size() && cyc < 400) begin
      if (stall > 0 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        check("stall_hold_byte", 64'(bus.out_byte), 64'(exp_q[0]));
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        stall--;
      end else begin
        bus.out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("byte", 64'(bus.out_byte), 64'(exp_q[got]));
        check("last", 64'(bus.out_last), 64'(got == exp_q.size() - 1));
        check("count", 64'(bus.out_count), 64'(exp_q.size()));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < exp_q.size()) check("stream_timeout_bytes", 64'(got), 64'(exp_q.size()));
    check("idle_after_last", 64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_t r;
    int   hs, cyc;
    logic [3:0] lens[5];
    lens = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8};

    tbl[0]  = '{mk(0, 1, 8'h01, 1, 4'd3, 3'd0, 4'd0, 32'h0, 64'h0, 4'd0), 3, 136'h4801D8, 0, 0};
    tbl[1]  = '{mk(0, 1, 8'hBC, 0, 4'd0, 3'd0, 4'd12, 32'h0, 64'h1122334455667788, 4'd8),
                10, 136'h49BC8877665544332211, 0, 0};
    tbl[2]  = '{mk(0, 0, 8'h8B, 1, 4'd0, 3'd1, 4'd5, 32'h0, 64'h0, 4'd0), 3, 136'h8B4500, 0, 0};
    tbl[3]  = '{mk(0, 0, 8'h8B, 1, 4'd0, 3'd2, 4'd4, 32'h10, 64'h0, 4'd0), 4, 136'h8B442410, 0, 0};
    tbl[4]  = '{mk(0, 0, 8'h8B, 1, 4'd0, 3'd4, 4'd0, 32'h00001000, 64'h0, 4'd0),
                6, 136'h8B0500100000, 0, 0};
    tbl[5]  = '{mk(1, 0, 8'h81, 1, 4'd0, 3'd0, 4'd1, 32'h0, 64'h1234, 4'd2),
                5, 136'h6681C13412, 0, 3};
    tbl[6]  = '{mk(0, 0, 8'h05, 0, 4'd0, 3'd0, 4'd0, 32'h0, 64'h0, 4'd3), 0, 136'h0, 1, 0};
    tbl[7]  = '{mk(0, 0, 8'h8B, 1, 4'd0, 3'd5, 4'd0, 32'h0, 64'h0, 4'd0), 0, 136'h0, 1, 0};
    tbl[8]  = '{mk(0, 0, 8'h90, 0, 4'd0, 3'd7, 4'd0, 32'h0, 64'h0, 4'd0), 1, 136'h90, 0, 0};
    tbl[9]  = '{mk(0, 0, 8'h50, 0, 4'd8, 3'd0, 4'd8, 32'h0, 64'h0, 4'd0), 2, 136'h4150, 0, 0};
    tbl[10] = '{mk(1, 1, 8'h81, 1, 4'd8, 3'd3, 4'd4, 32'h04030201, 64'h0C0B0A0908070605, 4'd8),
                17, 136'h664C818424_0102030405060708090A0B0C, 0, 0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    apply(mk(0, 0, 8'h00, 0, 4'd0, 3'd0, 4'd0, 32'h0, 64'h0, 4'd0));
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_out_byte", 64'(bus.out_byte), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      load_vec(i);
      send(tbl[i].r, tbl[i].stall, 1'b0);
    end

    // Reset while the displacement is on the bus, then a clean request afterwards.
    apply(tbl[4].r);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    hs  = 0;
    cyc = 0;
    while (hs < 2 && cyc < 20) begin
      if (bus.out_valid) hs++;
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_in_disp", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mid_count", 64'(bus.out_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_vec(0);
    send(tbl[0].r, 0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      r = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom_range(0, 3) != 0), 4'($urandom),
             ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
             4'($urandom), $urandom, {$urandom, $urandom},
             ($urandom_range(0, 19) == 0) ? 4'($urandom) : lens[$urandom_range(0, 4)]);
      model(r);
      send(r, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
